cnn_mac_pipe: RTL and testbench
===============================

CNN_MAC_PIPE -- requirements
Module: cnn_mac_pipe

Interface
REQ-001 Parameter A_W, default 9: width of unsigned activation operand din0.
REQ-002 Parameter B_W, default 14: width of signed weight operand din1.
REQ-003 Parameter ACC_W, default 32: signed accumulator width; legal range is ACC_W >= A_W+B_W+1.
REQ-004 Parameter OUT_W, default 16: signed result width; legal range is OUT_W <= ACC_W.
REQ-005 Parameter MUL_STAGES, default 2: register stages in the multiplier; legal range is 1..4.
REQ-006 Parameter FRAC_SHIFT, default 8: arithmetic right shift applied to the result; legal range is 0..ACC_W-OUT_W.
REQ-007 Port ap_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port ap_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 Port ce, input, 1 bit: clock enable; when low, every register holds.
REQ-010 Port in_valid, input, 1 bit: din0, din1, in_first and in_last are valid this cycle.
REQ-011 Port in_first, input, 1 bit: this beat opens an accumulation window.
REQ-012 Port in_last, input, 1 bit: this beat closes an accumulation window.
REQ-013 Port din0, input, A_W bits: unsigned operand.
REQ-014 Port din1, input, B_W bits: signed two's-complement operand.
REQ-015 Port out_valid, output, 1 bit: dout and sat_flag are valid this cycle.
REQ-016 Port dout, output, OUT_W bits: signed window result.
REQ-017 Port sat_flag, output, 1 bit: dout was clipped this cycle.

Function
REQ-018 The product SHALL be the signed (A_W+B_W)-bit value {1'b0,din0} times din1, exact, with no truncation.
REQ-019 With ce held high, a beat with in_valid and in_last SHALL produce out_valid exactly MUL_STAGES+2 cycles later, and the block SHALL accept one beat per cycle with no bubbles.
REQ-020 Pipeline order SHALL be: MUL_STAGES product registers, then one accumulator register, then one output register.
REQ-021 A valid beat with in_first SHALL load the accumulator with the sign-extended product, discarding the prior value.
REQ-022 A valid beat without in_first SHALL add the product to the accumulator, using two's-complement wrap at ACC_W.
REQ-023 After a beat carrying in_last, the accumulator SHALL read as 0; a following beat without in_first therefore starts from 0.
REQ-024 A beat with in_first and in_last both high SHALL be a one-term window whose result is its own product.
REQ-025 Beats with in_valid low SHALL not change the accumulator and SHALL not produce output; gaps inside a window are legal.
REQ-026 Output stage: r = (acc + (FRAC_SHIFT>0 ? 2^(FRAC_SHIFT-1) : 0)) >>> FRAC_SHIFT, computed in ACC_W+1 bits, i.e. round half toward +inf.
REQ-027 If r exceeds 2^(OUT_W-1)-1, dout SHALL be that maximum; if r is below -2^(OUT_W-1), dout SHALL be that minimum; sat_flag SHALL be 1 only in these two cases.
REQ-028 out_valid SHALL be a one-cycle pulse per window, and SHALL be held while ce is low.
REQ-029 Valid bits SHALL travel with the data through every stage, and ce low SHALL freeze data and valid bits together.

Reset
REQ-030 When ap_rst_n is low at a rising edge, all valid bits, the accumulator, dout, out_valid and sat_flag SHALL become 0, regardless of ce.
REQ-031 Reset mid-window SHALL discard the window and all in-flight beats, with no out_valid for them; the first beat after release is treated per REQ-021..023.

Structure
REQ-032 Package cnn_mac_pkg SHALL hold the default parameter constants and a saturation/rounding function shared with later CNN blocks.
REQ-033 The multiplier pipeline SHALL be one sub-module, cnn_mac_mul_pipe, which has ce, a valid sideband and MUL_STAGES registers; accumulation and output logic stay in the top module.

Verification
REQ-034 Defaults, FRAC_SHIFT=2: beats (10,5,first), (20,-3), (1,100,last) -> exactly one out_valid at cycle 4 after the last beat, with dout=23 and sat_flag=0.
REQ-035 Same window with din1 negated, i.e. (10,-5), (20,3), (1,-100) -> dout=-22 and sat_flag=0.
REQ-036 FRAC_SHIFT=0, OUT_W=16: one beat (255,-8192,first+last) -> dout=-32768 and sat_flag=1; the same beat with din1=8191 -> dout=32767 and sat_flag=1.
REQ-037 Back-to-back one-term windows on every cycle, with ce toggled randomly -> results match a reference model in order, none lost or duplicated, and out_valid held during ce low.
REQ-038 ap_rst_n pulsed low after the 2nd beat of a 3-beat window, then a new window (2,3,first+last) -> only one out_valid, with dout rounding 6>>>FRAC_SHIFT, and no output from the aborted window.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// Shared constants and the round/saturate helper for the CNN MAC family.
// The helper works in 64-bit signed arithmetic so any ACC_W below 63 fits.
package cnn_mac_pkg;

  localparam int A_W_DEF        = 9;
  localparam int B_W_DEF        = 14;
  localparam int ACC_W_DEF      = 32;
  localparam int OUT_W_DEF      = 16;
  localparam int MUL_STAGES_DEF = 2;
  localparam int FRAC_SHIFT_DEF = 8;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } sat_res_t;

  // Round half toward +inf, shift right arithmetically, clip to out_w signed bits.
  function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                         input int frac, input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t res;
    r = acc;
    if (frac > 0) r = r + (64'sd1 <<< (frac - 1));
    r = r >>> frac;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Unsigned x signed multiplier, MUL_STAGES registers deep, window flags riding along.
// Latency MUL_STAGES; no backpressure, ce low freezes data and valid together.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = A_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   in_vld,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [A_W-1:0]         a_dat,
  input  logic [B_W-1:0]         b_dat,
  output logic                   out_vld,
  output logic                   out_first,
  output logic                   out_last,
  output logic [A_W+B_W-1:0]     prod_dat
);

  localparam int P_W = A_W + B_W;

  logic [MUL_STAGES-1:0] vld_q;
  logic [MUL_STAGES-1:0] first_q;
  logic [MUL_STAGES-1:0] last_q;
  logic signed [P_W-1:0] prod_q [MUL_STAGES];
  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;

  // Both operands widened to the full product width so the multiply is exact.
  assign a_ext = $signed({{B_W{1'b0}}, a_dat});
  assign b_ext = $signed({{A_W{b_dat[B_W-1]}}, b_dat});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (ce) begin
      vld_q[0] <= in_vld;
      for (int i = 1; i < MUL_STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      prod_q[0]  <= a_ext * b_ext;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod_q[i]  <= prod_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign out_vld   = vld_q[MUL_STAGES-1];
  assign out_first = first_q[MUL_STAGES-1];
  assign out_last  = last_q[MUL_STAGES-1];
  assign prod_dat  = prod_q[MUL_STAGES-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Windowed multiply-accumulate with rounding and saturating output, one beat per cycle.
// Latency MUL_STAGES+2 from the closing beat; no backpressure, ce low freezes every stage.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = A_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             sat_flag
);

  localparam int P_W = A_W + B_W;

  logic                    mul_vld;
  logic                    mul_first;
  logic                    mul_last;
  logic [P_W-1:0]          mul_dat;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] fin_q;
  logic                    fin_vld;
  logic signed [63:0]      fin_ext;
  sat_res_t                res;

  cnn_mac_mul_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .ce        (ce),
    .in_vld    (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .a_dat     (din0),
    .b_dat     (din1),
    .out_vld   (mul_vld),
    .out_first (mul_first),
    .out_last  (mul_last),
    .prod_dat  (mul_dat)
  );

  assign prod_ext = $signed({{(ACC_W-P_W){mul_dat[P_W-1]}}, mul_dat});
  assign acc_nxt  = (mul_first ? '0 : acc_q) + prod_ext;

  // The closing sum is parked in fin_q so acc_q can restart from zero on the same edge.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q   <= '0;
      fin_q   <= '0;
      fin_vld <= 1'b0;
    end else if (ce) begin
      fin_vld <= mul_vld && mul_last;
      if (mul_vld) begin
        fin_q <= acc_nxt;
        acc_q <= mul_last ? '0 : acc_nxt;
      end
    end
  end

  assign fin_ext = $signed({{(64-ACC_W){fin_q[ACC_W-1]}}, fin_q});

  always_comb begin
    res = sat_round(fin_ext, FRAC_SHIFT, OUT_W);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat_flag  <= 1'b0;
    end else if (ce) begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        dout     <= OUT_W'(res.val);
        sat_flag <= res.sat;
      end
    end
  end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Randomized and directed bench: two instances (FRAC_SHIFT 2 and 0) share stimulus
// and are scored against a window-sum reference model with real-valued rounding.
module tb_cnn_mac_pipe;

  localparam int M = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n, ce, in_valid, in_first, in_last;
  logic [8:0]  din0;
  logic [13:0] din1;
  logic        ov_a, sat_a, ov_b, sat_b;
  logic [15:0] dout_a, dout_b;

  always #5 ap_clk = ~ap_clk;

  cnn_mac_pipe #(.FRAC_SHIFT(2)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(ov_a), .dout(dout_a), .sat_flag(sat_a)
  );

  cnn_mac_pipe #(.FRAC_SHIFT(0)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(ov_b), .dout(dout_b), .sat_flag(sat_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int     edge_no;
    longint da;
    bit     sa;
    longint db;
    bit     sb;
  } exp_t;

  exp_t   q[$];
  exp_t   e;
  int     sum = 0;
  int     p;
  int     edge_cnt = 0;
  int     phase = 2;  // 0 active edge, 1 ce-frozen edge, 2 reset edge
  int     n_out = 0;
  longint last_da, last_db;
  bit     last_sa, last_sb;
  logic   prev_ov;
  logic [15:0] prev_da;

  function automatic void round_sat(input int s, input int frac,
                                    output longint d, output bit sat);
    real r;
    r   = $floor(real'(s) / (2.0 ** frac) + 0.5);
    d   = longint'(r);
    sat = 1'b0;
    if (d > 32767) begin
      d = 32767; sat = 1'b1;
    end else if (d < -32768) begin
      d = -32768; sat = 1'b1;
    end
  endfunction

  // Reference model: window sums in 32-bit int, one expectation per closed window.
  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      q.delete();
      sum   = 0;
      phase = 2;
    end else if (!ce) begin
      phase = 1;
    end else begin
      phase = 0;
      edge_cnt++;
      if (in_valid) begin
        p   = int'(din0) * int'($signed(din1));
        sum = in_first ? p : sum + p;
        if (in_last) begin
          e.edge_no = edge_cnt + M + 1;
          round_sat(sum, 2, e.da, e.sa);
          round_sat(sum, 0, e.db, e.sb);
          q.push_back(e);
          sum = 0;
        end
      end
    end
  end

  always @(negedge ap_clk) begin
    if (phase == 2) begin
      check_val("rst_ov_a", ov_a, 0);
      check_val("rst_ov_b", ov_b, 0);
    end else if (phase == 1) begin
      check_val("hold_ov", ov_a, prev_ov);
      check_val("hold_dout", dout_a, prev_da);
    end else if (ov_a || ov_b) begin
      n_out++;
      last_da = $signed(dout_a);
      last_db = $signed(dout_b);
      last_sa = sat_a;
      last_sb = sat_b;
      if (q.size() == 0) begin
        check_val("extra_out", ov_a, 0);
      end else begin
        e = q.pop_front();
        check_val("ov_a", ov_a, 1);
        check_val("ov_b", ov_b, 1);
        check_val("latency", edge_cnt, e.edge_no);
        check_val("dout_f2", $signed(dout_a), e.da);
        check_val("sat_f2", sat_a, e.sa);
        check_val("dout_f0", $signed(dout_b), e.db);
        check_val("sat_f0", sat_b, e.sb);
      end
    end
    prev_ov = ov_a;
    prev_da = dout_a;
  end

  task automatic drive(input bit v, input bit f, input bit l,
                       input int a, input int b, input bit c);
    in_valid = v;
    in_first = f;
    in_last  = l;
    din0     = 9'(a);
    din1     = 14'(b);
    ce       = c;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1);
  endtask

  int n0;

  initial begin
    ap_rst_n = 1'b0;
    ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check_val("rst_dout_a", dout_a, 0);
    check_val("rst_sat_a", sat_a, 0);
    check_val("rst_dout_b", dout_b, 0);
    ap_rst_n = 1'b1;
    idle(2);

    n0 = n_out;
    drive(1, 1, 0, 10, 5, 1);
    drive(1, 0, 0, 20, -3, 1);
    drive(1, 0, 1, 1, 100, 1);
    idle(6);
    check_val("w1_count", n_out - n0, 1);
    check_val("w1_dout", last_da, 23);
    check_val("w1_sat", last_sa, 0);

    drive(1, 1, 0, 10, -5, 1);
    drive(1, 0, 0, 20, 3, 1);
    drive(1, 0, 1, 1, -100, 1);
    idle(6);
    check_val("w2_dout", last_da, -22);
    check_val("w2_sat", last_sa, 0);

    drive(1, 1, 1, 255, -8192, 1);
    idle(6);
    check_val("neg_sat_dout", last_db, -32768);
    check_val("neg_sat_flag", last_sb, 1);
    drive(1, 1, 1, 255, 8191, 1);
    idle(6);
    check_val("pos_sat_dout", last_db, 32767);
    check_val("pos_sat_flag", last_sb, 1);

    // Abort a window mid-flight; reset must win even with ce low.
    n0 = n_out;
    drive(1, 1, 0, 7, 9, 1);
    drive(1, 0, 0, 3, 4, 1);
    ap_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    ap_rst_n = 1'b1;
    drive(1, 1, 1, 2, 3, 1);
    idle(8);
    check_val("abort_count", n_out - n0, 1);
    check_val("abort_dout_f2", last_da, 2);
    check_val("abort_dout_f0", last_db, 6);

    for (int i = 0; i < 300; i++)
      drive(1, 1, 1, int'($urandom_range(0, 511)), int'($urandom_range(0, 16383)) - 8192,
            bit'($urandom_range(0, 1)));
    idle(8);

    for (int i = 0; i < 500; i++)
      drive(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
            int'($urandom_range(0, 511)), int'($urandom_range(0, 16383)) - 8192,
            ($urandom % 4) != 0);
    idle(10);
    check_val("pending", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
